// File: rtl/serializer_pkg.sv
// Shared state encodings for the parallel-in/serial-out serializer.
package serializer_pkg;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_SHIFT  = 2'd1;
    localparam logic [1:0] ENC_PARITY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ENC_IDLE,
        S_SHIFT  = ENC_SHIFT,
        S_PARITY = ENC_PARITY
    } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// 1-deep holding register: captures on set, empties on clr (set wins), flush empties it outright.
// Zero-latency visibility on the following cycle; the producer sees full via vld.
module ser_hold_buf
    import serializer_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         set,
    input  logic         clr,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    logic         vld_q;
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (!rst_b || flush) begin
            vld_q <= 1'b0;
            q_q   <= '0;
        end else if (set) begin
            vld_q <= 1'b1;
            q_q   <= d;
        end else if (clr) begin
            vld_q <= 1'b0;
        end
    end

    assign vld = vld_q;
    assign q   = q_q;

endmodule

// File: rtl/piso_serializer.sv
// PISO serializer with 1-deep input hold; first bit valid one cycle after acceptance, in_ready = hold empty.
// Optional trailing even-parity bit per word when SERIALIZER_PARITY_EN is defined.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             msb_first,
    input  logic             shift_en,
    input  logic             clr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic             hold_vld;
    logic [WIDTH:0]   hold_q;
    logic             accept;
    logic             load;
    logic             at_last;
    logic             end_tick;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    assign accept  = in_valid && !hold_vld;
    assign at_last = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

`ifdef SERIALIZER_PARITY_EN
    assign end_tick = (state_q == S_PARITY) && shift_en;
`else
    assign end_tick = at_last && shift_en;
`endif

    // Reload straight from hold on the final consume keeps back-to-back words gap-free.
    assign load = hold_vld && ((state_q == S_IDLE) || end_tick);

    ser_hold_buf #(
        .W (WIDTH + 1)
    ) u_hold (
        .clk   (clk),
        .rst_b (rst_b),
        .set   (accept),
        .clr   (load),
        .flush (clr),
        .d     ({msb_first, in_data}),
        .vld   (hold_vld),
        .q     (hold_q)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        order_d = order_q;
`ifdef SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (load) begin
            state_d = S_SHIFT;
            sh_d    = hold_q[WIDTH-1:0];
            order_d = hold_q[WIDTH];
            cnt_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            par_d   = ^hold_q[WIDTH-1:0];
`endif
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (shift_en) begin
                        sh_d = order_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
                        if (at_last) begin
                            cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (shift_en) begin
                        state_d = S_IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b || clr) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        ser_out = 1'b0;
        case (state_q)
            S_SHIFT:  ser_out = order_q ? sh_q[WIDTH-1] : sh_q[0];
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: ser_out = par_q;
`endif
            default:  ser_out = 1'b0;
        endcase
    end

    assign ser_valid = (state_q != S_IDLE);
    assign word_done = end_tick;
    assign in_ready  = !hold_vld;
    assign busy      = (state_q != S_IDLE) || hold_vld;

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised successor to the basic parallel-in/serial-out shifter.
- Accepts parallel words over a valid/ready handshake into a 1-deep holding buffer, so the next word is taken while the current one shifts.
- Shifts bits out one per `shift_en` tick, LSB- or MSB-first per word, and flags the last bit of each word.
- Feeds the serial link drivers downstream of the datapath.

Parameters:
- WIDTH, 32, data bits per word (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_b  in  1  synchronous active-low reset.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  holding buffer empty; word accepted when in_valid&&in_ready.
- msb_first  in  1  bit order, sampled with the word at acceptance.
- shift_en  in  1  bit tick; consumes the current bit when ser_valid.
- clr  in  1  synchronous flush.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out holds a live bit.
- word_done  out  1  last bit of the word consumed this cycle (combinational).
- busy  out  1  shifter or holding buffer occupied.

Behaviour:
- Reset (rst_b=0 at posedge): state=S_IDLE, hold empty, count=0, shifter=0.
  - Outputs after reset: in_ready=1, ser_valid=0, ser_out=0, word_done=0, busy=0.
- Priority: rst_b > clr > normal operation.
- clr: same effect as reset next cycle; any accepted or in-flight word is discarded.
- in_ready = ~hold_vld, driven from a register (no combinational path from shift_en).
- Acceptance at edge N: hold captures {msb_first, in_data}.
- Load into the shifter happens at the edge where either:
  - state=S_IDLE and hold_vld, or
  - state=S_SHIFT, shift_en=1, count=WIDTH-1, and hold_vld (back-to-back, zero-gap).
  - On load: hold_vld clears and count=0.
- Latency: a word accepted at edge N into an idle block gives ser_valid=1 after edge N+1; its first bit is on ser_out then.
- A new acceptance and a load from hold in the same cycle are legal. Hold sees clear and set together; set wins.
- States:
  - S_IDLE → S_SHIFT on load.
  - S_SHIFT → S_IDLE on the last-bit consume if hold is empty; stays in S_SHIFT on reload.
  - S_PARITY only with the optional feature enabled.
- In S_SHIFT:
  - ser_out = shifter[0] if LSB-first, shifter[WIDTH-1] if MSB-first.
  - shift_en=1: shift toward the output end, zero-fill, count+1.
  - shift_en=0: shifter, count and ser_out hold stable.
- word_done = (state==S_SHIFT) && shift_en && (count==WIDTH-1).
- ser_valid=0 in S_IDLE; ser_out is forced to 0 whenever ser_valid=0.
- shift_en in S_IDLE is ignored.
- Count never exceeds WIDTH-1 and never wraps.
- busy = (state!=S_IDLE) || hold_vld.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Enabled:
  - After the WIDTH-th bit is consumed, the FSM enters S_PARITY and presents one even-parity bit (XOR of the word) with ser_valid=1.
  - word_done moves to the parity consume instead of bit WIDTH-1.
  - Back-to-back reload occurs on the parity consume.
  - Parity is computed at load time and stored in a 1-bit register.
- Disabled: no S_PARITY, no parity register; a word is exactly WIDTH bits.

Decomposition:
- Package serializer_pkg:
  - typedef enum logic [1:0] ser_state_e {S_IDLE, S_SHIFT, S_PARITY}.
  - Localparam constants for the encodings.
- One sub-module: ser_hold_buf, a 1-deep valid/ready holding register.
  - Data width WIDTH+1: word plus order bit.
  - Ports: set, clr, flush; outputs vld and q.
- Shifter, counter and FSM stay in the top module.

Test Plan (WIDTH=8):
- Reset: rst_b=0 for 2 cycles, then 1 → in_ready=1, ser_valid=0, ser_out=0, busy=0, word_done=0.
- LSB-first: 8'h1E, msb_first=0, shift_en=1 constantly → ser_out 0,1,1,1,1,0,0,0; word_done high only on the 8th bit; in_ready=1 again on the cycle after acceptance.
- MSB-first with stalls: 8'h1E, msb_first=1, shift_en toggling 1,0 → ser_out 0,0,0,1,1,1,1,0, each bit held stable through the stall cycle; 16 cycles to word_done.
- Back-to-back: 8'h01 (LSB-first) then 8'h80 (MSB-first) offered consecutively, shift_en=1 → 16 contiguous bits 1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0 with no ser_valid gap; in_ready=0 while 8'h80 waits in hold; two word_done pulses 8 cycles apart.
- Flush: clr after 3 bits of 8'hFF with 8'hAA held → next cycle ser_valid=0, in_ready=1, busy=0; 8'hAA never appears; the same check is repeated with rst_b=0 instead of clr.
- Parity (SERIALIZER_PARITY_EN defined): 8'h07 LSB-first → 9 bits 1,1,1,0,0,0,0,0,1; word_done on the 9th bit. Repeated with 8'h03 → 9th bit 0.
